// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//   Walks the enabled ADC channels in ascending order, requests 2^AVG_LOG2
//   conversions per channel from the SPI capture engine, and stores the
//   truncated mean of each visit in an 8-entry result file.
//
// Ports
//   clk25, rst           : clock, asynchronous active-high reset
//   enable, chan_mask    : run control and channel enables (bit n = channel n)
//   ctl_valid, address   : conversion request to the capture engine
//   adc_ready, d_signal  : capture result and its valid flag
//   adc_ack              : result acknowledge
//   rd_addr, rd_data     : combinational read port of the result file
//   fresh, rd_clr        : per-channel "new result" flags, cleared via rd_addr
//   scan_done            : one-cycle pulse after the last channel of a scan
//   busy                 : sequencer is not idle
//
// Handshake (four-phase): ctl_valid rises and stays high until adc_ready is
// seen; ctl_valid then drops and adc_ack rises in the same edge; adc_ack
// stays high until adc_ready is seen low. ctl_valid and adc_ack are never
// high together, and address is stable whenever either one is high.
module adc_scan_sequencer #(
  parameter int AVG_LOG2   = 2,
  parameter int SCAN_PAUSE = 0
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  chan_mask,
  output logic        ctl_valid,
  output logic [2:0]  address,
  input  logic        adc_ready,
  input  logic [11:0] d_signal,
  output logic        adc_ack,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic [7:0]  fresh,
  input  logic        rd_clr,
  output logic        scan_done,
  output logic        busy
);

  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int PCNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_REQ, S_ACK, S_STORE, S_PAUSE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cur_q, cur_d;
  logic [2:0]         addr_q, addr_d;
  logic [7:0]         mask_q, mask_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               ctl_valid_q, ctl_valid_d;
  logic               adc_ack_q, adc_ack_d;
  logic               scan_done_q, scan_done_d;
  logic               busy_q, busy_d;
  logic [7:0]         fresh_q, fresh_d;
  logic [11:0]        result_q [8];
  logic [11:0]        result_d [8];

  logic               sel_found;
  logic [2:0]         sel_chan;
  logic [2:0]         last_chan;
  logic               is_last;
  logic               hs_accept;

  // Lowest enabled channel at or above cur, wrapping past 7. Scanning the
  // offsets downwards lets the smallest offset win.
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = cur_q;
    for (int i = 7; i >= 0; i--) begin
      if (chan_mask[cur_q + 3'(i)]) begin
        sel_found = 1'b1;
        sel_chan  = cur_q + 3'(i);
      end
    end
  end

  // Highest enabled channel of the mask latched in SEL marks the scan end.
  always_comb begin
    last_chan = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i]) last_chan = 3'(i);
    end
  end

  assign is_last   = (addr_q == last_chan);
  // A result only counts while our request is actually on the wire.
  assign hs_accept = ctl_valid_q & adc_ready;

  // State register and all datapath flops.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= 3'd0;
      addr_q      <= 3'd0;
      mask_q      <= 8'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      ctl_valid_q <= 1'b0;
      adc_ack_q   <= 1'b0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
      fresh_q     <= 8'd0;
      for (int i = 0; i < 8; i++) result_q[i] <= 12'd0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      ctl_valid_q <= ctl_valid_d;
      adc_ack_q   <= adc_ack_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
      fresh_q     <= fresh_d;
      for (int i = 0; i < 8; i++) result_q[i] <= result_d[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable && (chan_mask != 8'd0)) state_d = S_SEL;
      S_SEL:   state_d = sel_found ? S_REQ : S_IDLE;
      S_REQ:   if (hs_accept) state_d = S_ACK;
      S_ACK: begin
        if (!adc_ready) begin
          if (cnt_q == CNT_W'(NSAMP)) state_d = S_STORE;
          else if (enable)            state_d = S_REQ;
          else                        state_d = S_IDLE;
        end
      end
      S_STORE: begin
        if (!enable)                         state_d = S_IDLE;
        else if (is_last && SCAN_PAUSE > 0)  state_d = S_PAUSE;
        else                                 state_d = S_SEL;
      end
      S_PAUSE: if (pcnt_q == PCNT_W'(SCAN_PAUSE - 1)) state_d = S_SEL;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic; every output is the registered copy of these.
  always_comb begin
    cur_d       = cur_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    scan_done_d = 1'b0;
    fresh_d     = fresh_q;
    result_d    = result_q;

    // Request held until the engine answers; ack mirrors adc_ready in ACK.
    ctl_valid_d = (state_q == S_REQ) && !hs_accept;
    adc_ack_d   = ((state_q == S_REQ) && hs_accept) ||
                  ((state_q == S_ACK) && adc_ready);
    busy_d      = (state_d != S_IDLE);

    if (rd_clr) fresh_d[rd_addr] = 1'b0;

    case (state_q)
      S_IDLE: begin
        cur_d = 3'd0;
        acc_d = '0;
        cnt_d = '0;
      end
      S_SEL: begin
        mask_d = chan_mask;
        acc_d  = '0;
        cnt_d  = '0;
        if (sel_found) addr_d = sel_chan;
      end
      S_REQ: begin
        if (hs_accept) begin
          acc_d = acc_q + ACC_W'(d_signal);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STORE: begin
        result_d[addr_q] = acc_q[AVG_LOG2 +: 12];
        // Written after the rd_clr default so a same-cycle set wins.
        fresh_d[addr_q]  = 1'b1;
        scan_done_d      = is_last;
        cur_d            = is_last ? 3'd0 : addr_q + 3'd1;
        pcnt_d           = '0;
      end
      S_PAUSE: begin
        cur_d  = 3'd0;
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
      default: ;
    endcase
  end

  assign ctl_valid = ctl_valid_q;
  assign address   = addr_q;
  assign adc_ack   = adc_ack_q;
  assign scan_done = scan_done_q;
  assign busy      = busy_q;
  assign fresh     = fresh_q;
  assign rd_data   = result_q[rd_addr];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer. Three instances cover AVG_LOG2 = 2, 0 and 4;
// a behavioural model averages whatever samples the bench hands to each
// channel and a per-cycle compare process checks results, fresh flags and
// scan counts whenever the sequencer is requesting or idle.
module tb_adc_scan_sequencer;

  logic              clk25 = 1'b0;
  logic              rst   = 1'b1;
  logic [2:0]        en     = '0;
  logic [2:0]        ready  = '0;
  logic [2:0]        rd_clr = '0;
  logic [2:0][7:0]   mask    = '0;
  logic [2:0][11:0]  d       = '0;
  logic [2:0][2:0]   rd_addr = '0;

  wire  [2:0]        ctl_valid, adc_ack, scan_done, busy;
  wire  [2:0][7:0]   fresh;
  wire  [2:0][11:0]  rd_data;
  wire  [2:0][2:0]   address;

  // Model state
  int unsigned       acc_m [3][8];
  int                cnt_m [3][8];
  logic [11:0]       exp_res [3][8];
  logic [7:0]        exp_fresh [3];
  int                scans_m [3] = '{0, 0, 0};
  int                sd_cnt  [3] = '{0, 0, 0};
  int                navg    [3] = '{4, 1, 16};
  logic [2:0]        exp_q [$];

  int                tests  = 0;
  int                failed = 0;
  logic [2:0]        prev_hs = '0;
  logic [2:0][2:0]   prev_addr = '0;

  adc_scan_sequencer #(.AVG_LOG2(2), .SCAN_PAUSE(0)) dut_a (
    .clk25(clk25), .rst(rst), .enable(en[0]), .chan_mask(mask[0]),
    .ctl_valid(ctl_valid[0]), .address(address[0]), .adc_ready(ready[0]),
    .d_signal(d[0]), .adc_ack(adc_ack[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .fresh(fresh[0]), .rd_clr(rd_clr[0]),
    .scan_done(scan_done[0]), .busy(busy[0]));

  adc_scan_sequencer #(.AVG_LOG2(0), .SCAN_PAUSE(3)) dut_b (
    .clk25(clk25), .rst(rst), .enable(en[1]), .chan_mask(mask[1]),
    .ctl_valid(ctl_valid[1]), .address(address[1]), .adc_ready(ready[1]),
    .d_signal(d[1]), .adc_ack(adc_ack[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .fresh(fresh[1]), .rd_clr(rd_clr[1]),
    .scan_done(scan_done[1]), .busy(busy[1]));

  adc_scan_sequencer #(.AVG_LOG2(4), .SCAN_PAUSE(0)) dut_c (
    .clk25(clk25), .rst(rst), .enable(en[2]), .chan_mask(mask[2]),
    .ctl_valid(ctl_valid[2]), .address(address[2]), .adc_ready(ready[2]),
    .d_signal(d[2]), .adc_ack(adc_ack[2]), .rd_addr(rd_addr[2]),
    .rd_data(rd_data[2]), .fresh(fresh[2]), .rd_clr(rd_clr[2]),
    .scan_done(scan_done[2]), .busy(busy[2]));

  // Clock / watchdog
  always #5 clk25 = ~clk25;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  // Model: each channel averages groups of navg samples, truncating.
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      exp_fresh[k] = 8'd0;
      for (int c = 0; c < 8; c++) begin
        acc_m[k][c] = 0; cnt_m[k][c] = 0; exp_res[k][c] = 12'd0;
      end
    end
  endtask

  task automatic model_add(input int k, input logic [2:0] a, input logic [11:0] s);
    acc_m[k][a] += s;
    cnt_m[k][a]++;
    if (cnt_m[k][a] == navg[k]) begin
      exp_res[k][a]   = 12'(acc_m[k][a] / navg[k]);
      exp_fresh[k][a] = 1'b1;
      if (int'(a) == top_bit(mask[k])) scans_m[k]++;
      acc_m[k][a] = 0;
      cnt_m[k][a] = 0;
    end
  endtask

  task automatic model_discard(input int k, input logic [2:0] a);
    acc_m[k][a] = 0;
    cnt_m[k][a] = 0;
  endtask

  // Compare process: handshake rules every cycle, stored state whenever the
  // sequencer is requesting or idle (every finished group is stored by then).
  always @(posedge clk25) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (scan_done[i]) sd_cnt[i]++;
      if (!rst) begin
        check("hs_overlap", 32'(ctl_valid[i] & adc_ack[i]), 32'd0);
        if (prev_hs[i] && (ctl_valid[i] || adc_ack[i]))
          check("addr_stable", 32'(address[i]), 32'(prev_addr[i]));
        if (ctl_valid[i] || !busy[i]) begin
          check("rd_data_model", 32'(rd_data[i]), 32'(exp_res[i][rd_addr[i]]));
          check("fresh_model", 32'(fresh[i]), 32'(exp_fresh[i]));
          check("scan_cnt_model", sd_cnt[i], scans_m[i]);
        end
      end
      prev_hs[i]   = ctl_valid[i] | adc_ack[i];
      prev_addr[i] = address[i];
    end
  end

  // Driver tasks (capture-engine side)
  task automatic wait_req(input int k, output int waited);
    waited = 0;
    while (!ctl_valid[k] && waited < 300) begin
      @(negedge clk25);
      waited++;
    end
    check("req_seen", 32'(ctl_valid[k]), 32'd1);
  endtask

  task automatic serve(input int k, input logic [11:0] s, input int hold,
                       input bit clr_store, input bit drop_en,
                       output logic [2:0] a, output int waited);
    int n;
    a = '0;
    wait_req(k, waited);
    if (!ctl_valid[k]) return;
    a = address[k];
    d[k] = s;
    ready[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk25);
      n++;
    end while (!adc_ack[k] && n < 50);
    check("ack_latency", n, 1);
    model_add(k, a, s);
    if (drop_en) begin
      en[k] = 1'b0;
      model_discard(k, a);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk25);
      check("ack_held", 32'(adc_ack[k]), 32'd1);
      check("valid_low_in_ack", 32'(ctl_valid[k]), 32'd0);
    end
    ready[k] = 1'b0;
    if (clr_store) begin
      // Lands on the STORE edge of this channel: the set must win.
      @(negedge clk25);
      rd_addr[k] = a;
      rd_clr[k]  = 1'b1;
      @(negedge clk25);
      rd_clr[k]  = 1'b0;
    end
  endtask

  task automatic serve_chk(input int k, input logic [11:0] s, input int w_exp,
                           input int hold, input bit clr_store, input bit drop_en);
    logic [2:0] a;
    int w;
    serve(k, s, hold, clr_store, drop_en, a, w);
    check("req_addr", 32'(a), 32'(exp_q.pop_front()));
    if (w_exp >= 0) check("req_latency", w, w_exp);
  endtask

  task automatic clr(input int k, input logic [2:0] ch);
    rd_addr[k] = ch;
    rd_clr[k]  = 1'b1;
    exp_fresh[k][ch] = 1'b0;
    @(negedge clk25);
    rd_clr[k]  = 1'b0;
  endtask

  initial begin
    int w;
    model_reset();
    repeat (3) @(negedge clk25);
    check("rst_ctl_valid", 32'(ctl_valid[0]), 32'd0);
    check("rst_adc_ack", 32'(adc_ack[0]), 32'd0);
    check("rst_address", 32'(address[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_fresh", 32'(fresh[0]), 32'd0);
    check("rst_scan_done", 32'(scan_done[0]), 32'd0);
    check("rst_rd_data", 32'(rd_data[0]), 32'd0);
    rst = 1'b0;

    // Single channel, 4-sample average: 100..103 -> 101
    mask[0] = 8'h01;
    en[0]   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(3'd0);
      serve_chk(0, 12'(100 + j), (j == 0) ? 3 : 2, 0, 1'b0, 1'b0);
    end
    wait_req(0, w);
    check("store_to_req_latency", w, 4);
    check("a_result0", 32'(rd_data[0]), 32'd101);
    check("a_fresh", 32'(fresh[0]), 32'h01);
    check("a_scan_done_cnt", sd_cnt[0], 1);
    check("a_next_addr", 32'(address[0]), 32'd0);
    clr(0, 3'd0);

    // adc_ready held 5 extra cycles; rd_clr collides with the STORE set
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(3'd0);
      serve_chk(0, 12'(200 + 4 * j), -1, (j == 0) ? 5 : 0, (j == 3), 1'b0);
    end
    wait_req(0, w);
    check("a_result_hold", 32'(rd_data[0]), 32'd206);
    check("a_fresh_set_wins", 32'(fresh[0]), 32'h01);
    check("a_scan_done_cnt2", sd_cnt[0], 2);

    // Enable dropped in ACK with 1 of 4 samples: handshake finishes, no store
    exp_q.push_back(3'd0);
    serve_chk(0, 12'd300, 0, 0, 1'b0, 1'b1);
    repeat (5) @(negedge clk25);
    check("a_drop_busy", 32'(busy[0]), 32'd0);
    check("a_drop_valid", 32'(ctl_valid[0]), 32'd0);
    check("a_drop_ack", 32'(adc_ack[0]), 32'd0);
    check("a_drop_result", 32'(rd_data[0]), 32'd206);
    check("a_drop_fresh", 32'(fresh[0]), 32'h01);

    // Reset while a request is outstanding
    mask[0] = 8'h06;
    en[0]   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(3'd1);
      serve_chk(0, 12'(10 * (j + 1)), (j == 0) ? 3 : 2, 0, 1'b0, 1'b0);
    end
    wait_req(0, w);
    check("a_ch2_addr", 32'(address[0]), 32'd2);
    rd_addr[0] = 3'd1;
    #1;
    check("a_ch1_result", 32'(rd_data[0]), 32'd25);
    rst = 1'b1;
    #1;
    check("arst_ctl_valid", 32'(ctl_valid[0]), 32'd0);
    check("arst_adc_ack", 32'(adc_ack[0]), 32'd0);
    check("arst_address", 32'(address[0]), 32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_fresh", 32'(fresh[0]), 32'd0);
    check("arst_result", 32'(rd_data[0]), 32'd0);
    model_reset();
    repeat (2) @(negedge clk25);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(3'd1);
      serve_chk(0, 12'd8, (j == 0) ? 3 : 2, 0, 1'b0, 1'b0);
    end
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(3'd2);
      serve_chk(0, 12'(j + 1), -1, 0, 1'b0, 1'b0);
    end
    wait_req(0, w);
    check("a_restart_result", 32'(rd_data[0]), 32'd8);
    check("a_restart_fresh", 32'(fresh[0]), 32'h06);
    check("a_restart_scans", sd_cnt[0], 3);
    exp_q.push_back(3'd1);
    serve_chk(0, 12'd0, 0, 0, 1'b0, 1'b1);
    repeat (4) @(negedge clk25);
    check("a_final_idle", 32'(busy[0]), 32'd0);

    // Mask A4, no averaging, 3-cycle scan pause: 2,5,7,2
    mask[1] = 8'hA4;
    en[1]   = 1'b1;
    exp_q.push_back(3'd2);
    serve_chk(1, 12'h111, 3, 0, 1'b0, 1'b0);
    exp_q.push_back(3'd5);
    serve_chk(1, 12'h222, 4, 0, 1'b0, 1'b0);
    wait_req(1, w);
    check("b_5_to_7_latency", w, 4);
    check("b_no_scan_done_yet", sd_cnt[1], 0);
    exp_q.push_back(3'd7);
    serve_chk(1, 12'h333, 0, 0, 1'b0, 1'b0);
    exp_q.push_back(3'd2);
    serve_chk(1, 12'h444, 7, 0, 1'b0, 1'b1);
    check("b_scan_done_after_7", sd_cnt[1], 1);
    rd_addr[1] = 3'd7;
    #1;
    check("b_result7", 32'(rd_data[1]), 32'h333);
    repeat (4) @(negedge clk25);
    rd_addr[1] = 3'd2;
    #1;
    check("b_result2", 32'(rd_data[1]), 32'h444);
    check("b_idle", 32'(busy[1]), 32'd0);
    check("b_fresh", 32'(fresh[1]), 32'hA4);

    // 16-sample average: full scale, then truncation of 15/16
    mask[2]    = 8'h08;
    en[2]      = 1'b1;
    rd_addr[2] = 3'd3;
    for (int j = 0; j < 16; j++) begin
      exp_q.push_back(3'd3);
      serve_chk(2, 12'hFFF, -1, 0, 1'b0, 1'b0);
    end
    wait_req(2, w);
    check("c_full_scale", 32'(rd_data[2]), 32'hFFF);
    for (int j = 0; j < 16; j++) begin
      exp_q.push_back(3'd3);
      serve_chk(2, (j == 15) ? 12'd15 : 12'd0, -1, 0, 1'b0, (j == 15));
    end
    repeat (6) @(negedge clk25);
    check("c_truncate", 32'(rd_data[2]), 32'd0);
    check("c_idle", 32'(busy[2]), 32'd0);
    check("c_fresh", 32'(fresh[2]), 32'h08);
    check("c_scans", sd_cnt[2], 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Channel sequencer and result store for the SPI ADC capture path. It drives the capture engine's request side (`ctl_valid`, `address`) and consumes its result side (`adc_ready`, `d_signal`, `adc_ack`). It walks the enabled channels in ascending order, takes 2^AVG_LOG2 conversions per channel, and writes the truncated mean into an 8-entry result register file. LED and debug logic reads results from that file instead of the raw `d_signal`.

## Interface
Parameters:
- `AVG_LOG2`, default 2: conversions averaged per channel per visit; range 0..4.
- `SCAN_PAUSE`, default 0: idle clk25 cycles inserted after each completed scan; 0 means no pause.

Ports:
- `clk25` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `enable` in 1: run scanning while high.
- `chan_mask` in 8: bit n enables channel n.
- `ctl_valid` out 1: conversion request to the capture engine.
- `address` out 3: channel for the current request.
- `adc_ready` in 1: capture result valid; held until acknowledged.
- `d_signal` in 12: capture result.
- `adc_ack` out 1: result acknowledge.
- `rd_addr` in 3: result read index.
- `rd_data` out 12: combinational read of result[`rd_addr`].
- `fresh` out 8: bit n is set when result[n] has been written since it was last read-cleared.
- `rd_clr` in 1: clears `fresh[rd_addr]` on a clk25 edge.
- `scan_done` out 1: one-cycle pulse when the last enabled channel of a scan is written.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEL, REQ, ACK, STORE, PAUSE.
- IDLE:
  - Goes to SEL when `enable`=1 and `chan_mask`≠0.
  - `chan_mask` is sampled only in SEL.
- SEL:
  - Picks the lowest enabled channel ≥ cur, wrapping past 7.
  - cur starts at 0 after reset or after leaving IDLE.
  - Clears the accumulator and sample counter, latches `address`, then goes to REQ.
  - If the mask is now 0, returns to IDLE.
- REQ:
  - `ctl_valid`=1.
  - On `adc_ready`=1: acc += `d_signal` (acc width 12+AVG_LOG2, no overflow possible), cnt++, `ctl_valid`←0, `adc_ack`←1, go to ACK.
- ACK:
  - Holds `adc_ack`=1 until `adc_ready`=0, then `adc_ack`←0.
  - If cnt = 2^AVG_LOG2, go to STORE.
  - Otherwise, if `enable`=1, go to REQ; if `enable`=0, go to IDLE and discard the partial accumulator.
- STORE:
  - result[address] ← acc[AVG_LOG2 +: 12] (truncating mean); set `fresh[address]`.
  - If address is the highest enabled bit of the latched mask, pulse `scan_done` and continue to PAUSE (SCAN_PAUSE>0) or SEL.
  - Otherwise continue to SEL with cur = address+1.
  - If `enable`=0, go to IDLE instead.
- PAUSE: counts SCAN_PAUSE cycles, then goes to SEL with cur=0.
- Four-phase handshake: `ctl_valid` and `adc_ack` are never high in the same cycle. `address` is constant while `ctl_valid` or `adc_ack` is high.
- `fresh`: a set from STORE and an `rd_clr` on the same index in the same cycle leave the bit set (set wins).
- Dropping `enable` never aborts a handshake in progress. The block finishes ACK first.

## Timing
- Reset values:
  - `ctl_valid`=0, `adc_ack`=0, `address`=0, `scan_done`=0, `busy`=0, `fresh`=0.
  - All results = 0, state = IDLE, cur=0, acc=0, cnt=0.
- All outputs except `rd_data` are registered.
- Handshake cycle timing:
  - `enable` rising at edge k → `ctl_valid`=1 at edge k+2 (IDLE→SEL→REQ).
  - `adc_ready` seen high at edge t → `ctl_valid`=0, `adc_ack`=1 after edge t.
  - `adc_ready` seen low at edge u → `adc_ack`=0 after edge u. Next `ctl_valid`=1 after edge u+1, or `rd_data` updates after edge u+1 via STORE.
- With `adc_ready` returning within 1 cycle, per-channel overhead beyond conversion time is ≤ 3 + 2·2^AVG_LOG2 cycles.
- `rd_data` reflects a STORE write in the cycle after the write edge.
- Reset asserted mid-handshake: `ctl_valid` and `adc_ack` drop asynchronously. No result is written.

## Test plan
- Mask 8'h01, AVG_LOG2=2, model returns 100,101,102,103 → result[0]=101, `fresh`=8'h01, `scan_done` pulses once, then a new request on address 0.
- Mask 8'hA4, AVG_LOG2=0 → request addresses 2,5,7,2,…; `scan_done` only after channel 7 is stored.
- AVG_LOG2=4, all 16 samples 12'hFFF → result=12'hFFF with no overflow. Samples 0,…,0,15 → result 0 (truncation).
- Hold `adc_ready` high 5 cycles after the ack → `adc_ack` stays high 5 cycles, `ctl_valid` stays 0, and no second sample is accumulated.
- Deassert `enable` during ACK with cnt=1 of 4 → the handshake completes, the FSM goes to IDLE, the result is unchanged and `fresh` is unchanged.
- Assert `rst` while `ctl_valid`=1 → all outputs return to reset values immediately. After release with `enable`=1, the scan restarts at the lowest enabled channel.
